vga_frame_regs: RTL

//  vga_clk-domain register bank for display-control state (cursor, palette, mode, scroll).

---
 rtl/vga_regs_pkg.sv | 28 ++
 rtl/vga_frame_edge.sv | 40 ++++
 rtl/vga_frame_regs.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_regs_pkg.sv
// vga_regs_pkg - shared constants and types for the VGA display-control register bank.
// Rev 1.0
`default_nettype none

package vga_regs_pkg;

  localparam int VGA_NUM_REGS  = 8;
  localparam int VGA_REG_WIDTH = 16;

  localparam int REG_MODE        = 0;
  localparam int REG_COLOR       = 1;
  localparam int REG_CURSOR_POS  = 2;
  localparam int REG_CURSOR_SCAN = 3;
  localparam int REG_START_ADDR  = 4;

  // Mode and colour take effect at once; cursor and scroll wait for frame start.
  localparam logic [VGA_NUM_REGS-1:0] VGA_IMMEDIATE_MASK =
      (VGA_NUM_REGS'(1) << REG_MODE) | (VGA_NUM_REGS'(1) << REG_COLOR);

  typedef logic [VGA_REG_WIDTH-1:0] vga_reg_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_frame_edge.sv
// vga_frame_edge - vsync assertion detect, registered frame_start pulse and frame counter.
// Rev 1.0
`default_nettype none

module vga_frame_edge #(
  parameter bit VSYNC_ACT_LOW = 1'b1,
  parameter int FCNT_WIDTH    = 8
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic                  vga_vsync,
  output logic                  fs,
  output logic                  frame_start,
  output logic [FCNT_WIDTH-1:0] frame_count
);

  logic vs_act;
  logic vs_act_q;

  assign vs_act = vga_vsync ^ VSYNC_ACT_LOW;
  assign fs     = vs_act & ~vs_act_q;

  // History resets to asserted so a vsync already active at reset release is not a frame start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_act_q    <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_act_q    <= vs_act;
      frame_start <= fs;
      if (fs) begin
        frame_count <= frame_count + FCNT_WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_frame_regs.sv
// vga_frame_regs - double-buffered display-control registers committed at frame start.
// Rev 1.0
`default_nettype none

module vga_frame_regs
  import vga_regs_pkg::*;
#(
  parameter int                   NUM_REGS       = 8,
  parameter int                   REG_WIDTH      = 16,
  parameter logic [NUM_REGS-1:0]  IMMEDIATE_MASK = '0,
  parameter logic [REG_WIDTH-1:0] RESET_VAL      = '0,
  parameter bit                   VSYNC_ACT_LOW  = 1'b1,
  parameter int                   FCNT_WIDTH     = 8,
  localparam int                  IW             = idx_width(NUM_REGS),
  localparam int                  NB             = REG_WIDTH / 8
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic [IW-1:0]                 wr_index,
  input  logic [REG_WIDTH-1:0]          wr_data,
  input  logic [NB-1:0]                 wr_bytesel,
  input  logic                          hold,
  input  logic                          vga_vsync,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]           pending,
  output logic                          commit,
  output logic                          frame_start,
  output logic [FCNT_WIDTH-1:0]         frame_count
);

  logic [REG_WIDTH-1:0] shadow [NUM_REGS];
  logic [REG_WIDTH-1:0] active [NUM_REGS];

  logic                 fs;
  logic                 in_range;
  logic                 wr_hit;
  logic [IW-1:0]        sel_idx;
  logic [REG_WIDTH-1:0] merged;
  logic [NUM_REGS-1:0]  wr_sel;
  logic [NUM_REGS-1:0]  pend_next;
  logic                 do_commit;

  vga_frame_edge #(
    .VSYNC_ACT_LOW (VSYNC_ACT_LOW),
    .FCNT_WIDTH    (FCNT_WIDTH)
  ) u_edge (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .vga_vsync   (vga_vsync),
    .fs          (fs),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // Only a non-power-of-two bank can see an index past its last register.
  generate
    if ((2 ** IW) > NUM_REGS) begin : g_range_check
      assign in_range = (32'(wr_index) < NUM_REGS);
    end else begin : g_range_full
      assign in_range = 1'b1;
    end
  endgenerate

  assign wr_hit  = wr_valid & in_range & (|wr_bytesel);
  assign sel_idx = in_range ? wr_index : '0;

  always_comb begin
    merged = shadow[sel_idx];
    for (int b = 0; b < NB; b++) begin
      if (wr_bytesel[b]) begin
        merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = wr_hit && (sel_idx == IW'(i));
    end
  end

  // A deferred write landing on the commit cycle joins this frame's update.
  assign pend_next = pending | (wr_sel & ~IMMEDIATE_MASK);
  assign do_commit = fs & ~hold & (|pend_next);

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VAL;
        active[i] <= RESET_VAL;
      end
      pending <= '0;
      commit  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          shadow[i] <= merged;
        end
        if (wr_sel[i] && IMMEDIATE_MASK[i]) begin
          active[i] <= merged;
        end else if (do_commit && pend_next[i]) begin
          active[i] <= wr_sel[i] ? merged : shadow[i];
        end
      end
      pending <= do_commit ? '0 : pend_next;
      commit  <= do_commit;
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign regs_out[i*REG_WIDTH +: REG_WIDTH] = active[i];
    end
  endgenerate

endmodule

`default_nettype wire
